branch_predictor: RTL and testbench

Dynamic branch predictor and mispredict detector for the 5-stage pipeline. It predicts direction and target for the fetch PC using a direct-mapped branch target buffer with 2-bit saturating counters. It resolves each control-flow instruction in execute and trains the table. It drives `flushBranch` into the hazard unit, plus the corrected PC into the fetch PC mux.

---
 rtl/branch_pkg.sv | 47 ++++
 rtl/btb_ram.sv | 44 ++++
 rtl/branch_predictor.sv | 117 +++++++++++
 tb/tb_branch_predictor.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/branch_pkg.sv
// Shared types and helpers for the branch predictor: counter encoding,
// BTB entry layout and saturating counter arithmetic.
package branch_pkg;

    // Entry fields are sized for the widest supported PC; narrower
    // instances zero-extend, leaving the unused upper bits constant.
    localparam int MAX_W = 64;

    typedef enum logic [1:0] {
        SNT = 2'b00,
        WNT = 2'b01,
        WT  = 2'b10,
        ST  = 2'b11
    } ctr_t;

    localparam ctr_t CTR_RESET = WNT;

    typedef struct packed {
        logic             valid;
        logic [MAX_W-1:0] tag;
        logic [MAX_W-1:0] target;
        ctr_t             ctr;
    } btb_entry_t;

    localparam btb_entry_t ENTRY_RESET = '{valid: 1'b0, tag: '0, target: '0, ctr: CTR_RESET};

    function automatic ctr_t ctr_inc(input ctr_t c);
        case (c)
            SNT:     return WNT;
            WNT:     return WT;
            WT:      return ST;
            ST:      return ST;
            default: return CTR_RESET;
        endcase
    endfunction

    function automatic ctr_t ctr_dec(input ctr_t c);
        case (c)
            SNT:     return SNT;
            WNT:     return SNT;
            WT:      return WNT;
            ST:      return WT;
            default: return CTR_RESET;
        endcase
    endfunction

endpackage

// File: rtl/btb_ram.sv
// Branch target buffer storage: register array with two asynchronous read
// ports (fetch, execute) and one synchronous write port.
import branch_pkg::*;

module btb_ram #(
    parameter int ENTRIES = 16,
    parameter int IDX     = $clog2(ENTRIES)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [IDX-1:0]   rd_idx_f,
    output btb_entry_t       rd_entry_f,
    input  logic [IDX-1:0]   rd_idx_e,
    output btb_entry_t       rd_entry_e,
    input  logic             we,
    input  logic [IDX-1:0]   wr_idx,
    input  btb_entry_t       wr_entry
);

    btb_entry_t mem_q [ENTRIES];
    btb_entry_t mem_d [ENTRIES];

    // Next-state of the array: only the addressed entry changes on a write.
    always_comb begin
        for (int i = 0; i < ENTRIES; i++) begin
            mem_d[i] = (we && (wr_idx == IDX'(i))) ? wr_entry : mem_q[i];
        end
    end

    // Array state; reset clears every entry, overriding any same-cycle write.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < ENTRIES; i++) begin
                mem_q[i] <= ENTRY_RESET;
            end
        end else begin
            mem_q <= mem_d;
        end
    end

    assign rd_entry_f = mem_q[rd_idx_f];
    assign rd_entry_e = mem_q[rd_idx_e];

endmodule

// File: rtl/branch_predictor.sv
// Dynamic branch predictor: BTB lookup at fetch, mispredict detection and
// redirect at execute, table training and performance counters.
import branch_pkg::*;

module branch_predictor #(
    parameter int ENTRIES = 16,
    parameter int WIDTH   = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] PCF,
    output logic             PredTakenF,
    output logic [WIDTH-1:0] PredTargetF,
    input  logic [WIDTH-1:0] PCE,
    input  logic             BranchE,
    input  logic             JumpE,
    input  logic             TakenE,
    input  logic [WIDTH-1:0] TargetE,
    input  logic             PredTakenE,
    input  logic [WIDTH-1:0] PredTargetE,
    output logic             flushBranch,
    output logic [WIDTH-1:0] PCCorrectE,
    output logic [31:0]      BranchCount,
    output logic [31:0]      MispredCount
);

    localparam int IDX   = $clog2(ENTRIES);
    localparam int TAG_W = WIDTH - IDX - 2;
    localparam logic [WIDTH-1:0] PC_STEP = {{(WIDTH-3){1'b0}}, 3'b100};

    logic [IDX-1:0]   idx_f, idx_e;
    logic [TAG_W-1:0] tag_f, tag_e;
    btb_entry_t       ent_f, ent_e, wr_entry;
    logic             hit_f, hit_e, cf, mispred, we;
    logic [31:0]      branch_count_d, branch_count_q;
    logic [31:0]      mispred_count_d, mispred_count_q;

    assign idx_f = PCF[IDX+1:2];
    assign tag_f = PCF[WIDTH-1:IDX+2];
    assign idx_e = PCE[IDX+1:2];
    assign tag_e = PCE[WIDTH-1:IDX+2];

    btb_ram #(.ENTRIES(ENTRIES), .IDX(IDX)) u_btb (
        .clk        (clk),
        .rst_n      (rst_n),
        .rd_idx_f   (idx_f),
        .rd_entry_f (ent_f),
        .rd_idx_e   (idx_e),
        .rd_entry_e (ent_e),
        .we         (we),
        .wr_idx     (idx_e),
        .wr_entry   (wr_entry)
    );

    assign hit_f       = ent_f.valid && (ent_f.tag[TAG_W-1:0] == tag_f);
    assign hit_e       = ent_e.valid && (ent_e.tag[TAG_W-1:0] == tag_e);
    assign PredTakenF  = hit_f && ent_f.ctr[1];
    assign PredTargetF = PredTakenF ? ent_f.target[WIDTH-1:0] : PCF + PC_STEP;

    // A prediction of taken on a non-control-flow instruction is stale or aliased.
    assign cf          = BranchE | JumpE;
    assign mispred     = cf ? ((TakenE != PredTakenE) || (TakenE && (TargetE != PredTargetE)))
                            : PredTakenE;
    assign flushBranch = mispred;
    assign PCCorrectE  = (cf && TakenE) ? TargetE : PCE + PC_STEP;

    // Training decode: update on hit, allocate on taken miss, drop stale entries.
    always_comb begin
        we       = 1'b0;
        wr_entry = ent_e;
        if (cf) begin
            if (hit_e) begin
                we = 1'b1;
                if (TakenE) begin
                    wr_entry.ctr    = ctr_inc(ent_e.ctr);
                    wr_entry.target = MAX_W'(TargetE);
                end else begin
                    wr_entry.ctr    = ctr_dec(ent_e.ctr);
                end
            end else if (TakenE) begin
                we              = 1'b1;
                wr_entry.valid  = 1'b1;
                wr_entry.tag    = MAX_W'(tag_e);
                wr_entry.target = MAX_W'(TargetE);
                wr_entry.ctr    = JumpE ? ST : WT;
            end else begin
                we = 1'b0;
            end
        end else if (PredTakenE && hit_e) begin
            we             = 1'b1;
            wr_entry.valid = 1'b0;
        end else begin
            we = 1'b0;
        end
    end

    // Performance counter next-state; both wrap naturally at 2^32.
    always_comb begin
        branch_count_d  = branch_count_q  + {31'd0, cf};
        mispred_count_d = mispred_count_q + {31'd0, mispred};
    end

    // Performance counter state.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            branch_count_q  <= 32'd0;
            mispred_count_q <= 32'd0;
        end else begin
            branch_count_q  <= branch_count_d;
            mispred_count_q <= mispred_count_d;
        end
    end

    assign BranchCount  = branch_count_q;
    assign MispredCount = mispred_count_q;

endmodule

// File: tb/tb_branch_predictor.sv
// Randomized scoreboard bench for branch_predictor against a table-level
// reference model of the BTB and counters.
module tb_branch_predictor;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] PCF, PredTargetF, PCE, TargetE, PredTargetE, PCCorrectE;
    logic        PredTakenF, BranchE, JumpE, TakenE, PredTakenE, flushBranch;
    logic [31:0] BranchCount, MispredCount;

    always #5 clk = ~clk;

    branch_predictor #(.ENTRIES(16), .WIDTH(32)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .PCF          (PCF),
        .PredTakenF   (PredTakenF),
        .PredTargetF  (PredTargetF),
        .PCE          (PCE),
        .BranchE      (BranchE),
        .JumpE        (JumpE),
        .TakenE       (TakenE),
        .TargetE      (TargetE),
        .PredTakenE   (PredTakenE),
        .PredTargetE  (PredTargetE),
        .flushBranch  (flushBranch),
        .PCCorrectE   (PCCorrectE),
        .BranchCount  (BranchCount),
        .MispredCount (MispredCount)
    );

    typedef struct {
        logic        pt;
        logic [31:0] ptgt;
        logic        fl;
        logic [31:0] pcc;
        logic [31:0] bc;
        logic [31:0] mc;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    // Reference model: per-entry fields with the counter as a plain 0..3 integer.
    bit          m_valid [16];
    logic [25:0] m_tag   [16];
    logic [31:0] m_tgt   [16];
    int          m_ctr   [16];
    logic [31:0] m_bc, m_mc;

    function automatic int idx_of(input logic [31:0] pc);
        return int'((pc >> 2) % 32'd16);
    endfunction

    function automatic logic [25:0] tag_of(input logic [31:0] pc);
        return pc[31:6];
    endfunction

    function automatic bit m_hit(input logic [31:0] pc);
        return m_valid[idx_of(pc)] && (m_tag[idx_of(pc)] == tag_of(pc));
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 16; i++) begin
            m_valid[i] = 1'b0;
            m_ctr[i]   = 1;
            m_tag[i]   = 26'd0;
            m_tgt[i]   = 32'd0;
        end
        m_bc = 32'd0;
        m_mc = 32'd0;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // One cycle of stimulus: predict the outputs, queue them, then advance the model.
    task automatic drive(input logic rst, input logic [31:0] pcf, input logic [31:0] pce,
                         input logic br, input logic jp, input logic tk, input logic [31:0] tgte,
                         input logic pte, input logic [31:0] ptgte);
        exp_t e;
        int   j;
        bit   cf, hite;
        rst_n = rst; PCF = pcf; PCE = pce; BranchE = br; JumpE = jp;
        TakenE = tk; TargetE = tgte; PredTakenE = pte; PredTargetE = ptgte;

        e.pt   = m_hit(pcf) && (m_ctr[idx_of(pcf)] >= 2);
        e.ptgt = e.pt ? m_tgt[idx_of(pcf)] : pcf + 32'd4;
        cf     = br || jp;
        e.fl   = cf ? ((tk != pte) || (tk && (tgte != ptgte))) : pte;
        e.pcc  = (cf && tk) ? tgte : pce + 32'd4;
        e.bc   = m_bc;
        e.mc   = m_mc;
        exp_q.push_back(e);

        if (!rst) begin
            model_reset();
        end else begin
            if (cf)   m_bc = m_bc + 32'd1;
            if (e.fl) m_mc = m_mc + 32'd1;
            j    = idx_of(pce);
            hite = m_hit(pce);
            if (cf) begin
                if (hite && tk) begin
                    m_ctr[j] = (m_ctr[j] == 3) ? 3 : m_ctr[j] + 1;
                    m_tgt[j] = tgte;
                end else if (hite) begin
                    m_ctr[j] = (m_ctr[j] == 0) ? 0 : m_ctr[j] - 1;
                end else if (tk) begin
                    m_valid[j] = 1'b1;
                    m_tag[j]   = tag_of(pce);
                    m_tgt[j]   = tgte;
                    m_ctr[j]   = jp ? 3 : 2;
                end
            end else if (pte && hite) begin
                m_valid[j] = 1'b0;
            end
        end
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] rand_pc();
        logic [31:0] tags [3];
        tags[0] = 32'd4; tags[1] = 32'd5; tags[2] = 32'd8;
        if ($urandom_range(0, 49) == 0) return 32'hFFFF_FFFC;
        return (tags[$urandom_range(0, 2)] << 6) | (32'($urandom_range(0, 3)) << 2);
    endfunction

    // Monitor: pops one expectation per presented cycle, sampled mid-cycle.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("PredTakenF",   {31'd0, PredTakenF},  {31'd0, e.pt});
                check("PredTargetF",  PredTargetF,          e.ptgt);
                check("flushBranch",  {31'd0, flushBranch}, {31'd0, e.fl});
                check("PCCorrectE",   PCCorrectE,           e.pcc);
                check("BranchCount",  BranchCount,          e.bc);
                check("MispredCount", MispredCount,         e.mc);
            end
        end
    end

    initial begin
        logic [31:0] pce, tgt, ptg;
        logic        br, jp, tk, pte;
        rst_n = 1'b0; PCF = 32'd0; PCE = 32'd0; BranchE = 1'b0; JumpE = 1'b0;
        TakenE = 1'b0; TargetE = 32'd0; PredTakenE = 1'b0; PredTargetE = 32'd0;
        @(posedge clk);
        #1;
        model_reset();

        // Reset state and first allocation.
        drive(1'b1, 32'h100, 32'h0,   1'b0, 1'b0, 1'b0, 32'h0,  1'b0, 32'h0);
        drive(1'b1, 32'h100, 32'h100, 1'b1, 1'b0, 1'b1, 32'h80, 1'b0, 32'h0);
        drive(1'b1, 32'h100, 32'h0,   1'b0, 1'b0, 1'b0, 32'h0,  1'b0, 32'h0);
        // Saturation walk: three taken then four not-taken at 0x100.
        for (int i = 0; i < 3; i++)
            drive(1'b1, 32'h100, 32'h100, 1'b1, 1'b0, 1'b1, 32'h80, 1'b1, 32'h80);
        for (int i = 0; i < 4; i++)
            drive(1'b1, 32'h100, 32'h100, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h104);
        drive(1'b1, 32'h100, 32'h100, 1'b1, 1'b0, 1'b1, 32'h80, 1'b0, 32'h0);
        // Aliasing at index 0, with a same-cycle write while fetch reads that index.
        drive(1'b1, 32'h140, 32'h140, 1'b1, 1'b0, 1'b1, 32'h300, 1'b0, 32'h0);
        drive(1'b1, 32'h100, 32'h0,   1'b0, 1'b0, 1'b0, 32'h0,   1'b0, 32'h0);
        drive(1'b1, 32'h140, 32'h0,   1'b0, 1'b0, 1'b0, 32'h0,   1'b0, 32'h0);
        // Stale prediction invalidates a jump entry at 0x200.
        drive(1'b1, 32'h200, 32'h200, 1'b0, 1'b1, 1'b1, 32'h400, 1'b0, 32'h0);
        drive(1'b1, 32'h200, 32'h200, 1'b0, 1'b0, 1'b0, 32'h0,   1'b1, 32'h400);
        drive(1'b1, 32'h200, 32'h0,   1'b0, 1'b0, 1'b0, 32'h0,   1'b0, 32'h0);
        // PC+4 wrap, then a resolution coinciding with reset is discarded.
        drive(1'b1, 32'hFFFF_FFFC, 32'hFFFF_FFFC, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
        drive(1'b0, 32'h100, 32'h100, 1'b1, 1'b0, 1'b1, 32'h80, 1'b0, 32'h0);
        drive(1'b1, 32'h100, 32'h0,   1'b0, 1'b0, 1'b0, 32'h0,  1'b0, 32'h0);

        // Randomized traffic, mostly plausible pipelined predictions.
        for (int n = 0; n < 3000; n++) begin
            pce = rand_pc();
            br  = ($urandom_range(0, 9) < 5);
            jp  = ($urandom_range(0, 9) < 2);
            tk  = jp ? 1'b1 : 1'($urandom_range(0, 1));
            tgt = {$urandom_range(0, 7) == 0 ? $urandom() : rand_pc()} & 32'hFFFF_FFFC;
            if ($urandom_range(0, 3) != 0) begin
                pte = m_hit(pce) && (m_ctr[idx_of(pce)] >= 2);
                ptg = pte ? m_tgt[idx_of(pce)] : pce + 32'd4;
            end else begin
                pte = 1'($urandom_range(0, 1));
                ptg = rand_pc();
            end
            drive(($urandom_range(0, 499) != 0), rand_pc(), pce, br, jp, tk, tgt, pte, ptg);
        end

        @(negedge clk);
        #1;
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
